clk_div_prog: RTL and testbench

Programmable clock/tick divider: next generation of the fixed half-period divider used for the reaction timer's timebase. Generates a divided square wave `clk_out` and a single-cycle strobe `tick` from the system clock. Divisor is run-time reloadable through a shadow register, applied glitch-free only at a terminal-count boundary. Adds enable, synchronous clear and an optional tick counter. One instance feeds the millisecond timebase; others drive display and LFSR delay timing.

---
 rtl/clk_div_prog.sv | 109 ++++++++++
 tb/tb_clk_div_prog.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable half-period divider with shadowed divisor reload.
// Define CLKDIV_TICK_CNT_EN to add the wrapping tick_cnt output.
module clk_div_prog #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_RESET = 24999,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
`ifdef CLKDIV_TICK_CNT_EN
  output logic [CNT_W-1:0] tick_cnt,
`endif
  output logic             load_pend
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_shd_q, div_shd_d;
  logic             load_pend_q, load_pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             tc;

  assign tc = en && (cnt_q == div_act_q);

  always_comb begin
    cnt_d       = cnt_q;
    div_act_d   = div_act_q;
    div_shd_d   = div_shd_q;
    load_pend_d = load_pend_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    if (clr) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      if (load_pend_q) begin
        div_act_d   = div_shd_q;
        load_pend_d = 1'b0;
      end
    end else if (tc) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = 1'b1;
      if (load_pend_q) begin
        div_act_d   = div_shd_q;
        load_pend_d = 1'b0;
      end
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
    // A new request always wins over the pend clear above
    if (div_load) begin
      div_shd_d   = div_in;
      load_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      div_act_q   <= WIDTH'(DIV_RESET);
      div_shd_q   <= '0;
      load_pend_q <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_act_q   <= div_act_d;
      div_shd_q   <= div_shd_d;
      load_pend_q <= load_pend_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign load_pend = load_pend_q;

`ifdef CLKDIV_TICK_CNT_EN
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clr) begin
      tick_cnt_d = '0;
    end else if (tick_q) begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with DIV_RESET=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic        div_load;
  logic [15:0] div_in;
  logic        clk_out;
  logic        tick;
  logic        load_pend;
`ifdef CLKDIV_TICK_CNT_EN
  logic [3:0]  tick_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  clk_div_prog #(
    .WIDTH(16),
    .DIV_RESET(3),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .en(en),
    .clr(clr),
    .div_load(div_load),
    .div_in(div_in),
    .clk_out(clk_out),
    .tick(tick),
`ifdef CLKDIV_TICK_CNT_EN
    .tick_cnt(tick_cnt),
`endif
    .load_pend(load_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag,
                      input logic c,
                      input logic t,
                      input logic p);
    chk({tag, ".clk_out"}, 32'(clk_out), 32'(c));
    chk({tag, ".tick"}, 32'(tick), 32'(t));
    chk({tag, ".load_pend"}, 32'(load_pend), 32'(p));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    div_load = 1'b0;
    div_in = '0;
    repeat (2) cyc();
    chk3("rst", 0, 0, 0);
    rst_n = 1'b1;
    en = 1'b1;
    // half-period 4: first toggle on 4th edge
    repeat (3) cyc();
    chk3("e3", 0, 0, 0);
    cyc(); chk3("e4", 1, 1, 0);
    cyc(); chk3("e5", 1, 0, 0);
    repeat (3) cyc();
    chk3("e8", 0, 1, 0);
    // freeze at cnt=2
    repeat (2) cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold.clk_out", 32'(clk_out), 32'd0);
      chk("hold.tick", 32'(tick), 32'd0);
    end
    en = 1'b1;
    cyc(); chk3("res1", 0, 0, 0);
    cyc(); chk3("res2", 1, 1, 0);
    // 5 then 2 before TC: only 2 applied
    div_load = 1'b1; div_in = 16'd5;
    cyc(); chk3("ld5", 1, 0, 1);
    div_in = 16'd2;
    cyc(); chk3("ld2", 1, 0, 1);
    div_load = 1'b0;
    cyc(); chk3("ldw", 1, 0, 1);
    cyc(); chk3("ldtc", 0, 1, 0);
    repeat (2) cyc();
    chk3("d2a", 0, 0, 0);
    cyc(); chk3("d2b", 1, 1, 0);
    // load 1 mid-period, then load 0 on the TC
    cyc();
    div_load = 1'b1; div_in = 16'd1;
    cyc(); chk3("ld1", 1, 0, 1);
    div_in = 16'd0;
    cyc(); chk3("cotc", 0, 1, 1);
    div_load = 1'b0;
    cyc(); chk3("d1a", 0, 0, 1);
    cyc(); chk3("d1b", 1, 1, 0);
    cyc(); chk3("d0a", 0, 1, 0);
    cyc(); chk3("d0b", 1, 1, 0);
    cyc(); chk3("d0c", 0, 1, 0);
    // load on TC with nothing pending waits a TC
    div_load = 1'b1; div_in = 16'd3;
    cyc(); chk3("tcnp", 1, 1, 1);
    div_load = 1'b0;
    cyc(); chk3("tcap", 0, 1, 0);
    repeat (3) cyc();
    chk3("d3a", 0, 0, 0);
    cyc(); chk3("d3b", 1, 1, 0);
    // clr with clk_out=1 and 0 pending
    cyc();
    div_load = 1'b1; div_in = 16'd0;
    cyc(); chk3("ld0", 1, 0, 1);
    div_load = 1'b0; clr = 1'b1;
    cyc(); chk3("clr", 0, 0, 0);
    clr = 1'b0;
    cyc(); chk3("c0a", 1, 1, 0);
    cyc(); chk3("c0b", 0, 1, 0);
    // clr coincident with load
    div_load = 1'b1; div_in = 16'd2;
    cyc(); chk3("ld2b", 1, 1, 1);
    div_in = 16'd3; clr = 1'b1;
    cyc(); chk3("clrld", 0, 0, 1);
    div_load = 1'b0; clr = 1'b0;
    repeat (2) cyc();
    chk3("c2a", 0, 0, 1);
    cyc(); chk3("c2b", 1, 1, 0);
    repeat (3) cyc();
    chk3("c3a", 1, 0, 0);
    cyc(); chk3("c3b", 0, 1, 0);
    // async reset while clk_out, tick, load_pend all high
    repeat (3) cyc();
    div_load = 1'b1; div_in = 16'd7;
    cyc(); chk3("pre", 1, 1, 1);
    div_load = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk3("arst", 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk3("r3", 0, 0, 0);
    cyc(); chk3("r4", 1, 1, 0);
    repeat (4) cyc();
    chk3("r8", 0, 1, 0);
`ifdef CLKDIV_TICK_CNT_EN
    div_load = 1'b1; div_in = 16'd0;
    cyc();
    div_load = 1'b0; clr = 1'b1;
    cyc(); chk("tc.clr", 32'(tick_cnt), 32'd0);
    clr = 1'b0;
    repeat (17) cyc();
    chk("tc.16", 32'(tick_cnt), 32'd0);
    cyc(); chk("tc.17", 32'(tick_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("tc.arst", 32'(tick_cnt), 32'd0);
    chk3("tcarst", 0, 0, 0);
    cyc();
    rst_n = 1'b1;
`endif
    cyc();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
